// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF fetch requester and the byte-wide memory controller.
// Grant codes are common to both sides of the arbitration interface.
package if_fetch_unit_pkg;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IF   = 2'b01;
  localparam logic [1:0] GRANT_MEM  = 2'b10;

  localparam int INST_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch requester: issues four byte reads through the memory controller,
// assembles them little-endian and hands the word to IF/ID with a valid/ready handshake.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_request_o,
  output logic [31:0] if_addr_o,
  input  logic [1:0]  grant_i,
  input  logic [7:0]  ram_byte_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  fetch_state_t state;
  logic [31:0]  base_pc;
  logic [2:0]   issue_cnt;
  logic [2:0]   recv_cnt;
  logic         vld_p1;
  logic [1:0]   lane_p1;
  logic [31:0]  word_p2;
  logic         req_live;

  // Outputs derive from registered state only; rst gates them low during reset.
  assign req_live     = (state == FETCH) && (issue_cnt < 3'(INST_BYTES));
  assign if_request_o = req_live && !rst;
  assign if_addr_o    = if_request_o ? (base_pc + {29'd0, issue_cnt}) : 32'd0;
  assign inst_valid_o = (state == DONE) && !rst;
  assign inst_o       = inst_valid_o ? word_p2 : 32'd0;
  assign inst_pc_o    = inst_valid_o ? base_pc : 32'd0;

  // Stage p0 -> p1: grant seen, byte for lane_p1 arrives next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      base_pc   <= RESET_PC;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      vld_p1    <= 1'b0;
    end else if (flush_i) begin
      state     <= FETCH;
      base_pc   <= flush_pc_i;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      vld_p1    <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (req_live && (grant_i == GRANT_IF)) begin
            issue_cnt <= issue_cnt + 3'd1;
            vld_p1    <= 1'b1;
            lane_p1   <= issue_cnt[1:0];
          end else begin
            vld_p1    <= 1'b0;
          end
          if (vld_p1) begin
            recv_cnt <= recv_cnt + 3'd1;
            if (recv_cnt == 3'(INST_BYTES - 1))
              state <= DONE;
          end
        end
        DONE: begin
          vld_p1 <= 1'b0;
          if (inst_ready_i) begin
            base_pc   <= base_pc + 32'd4;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Stage p1 -> p2: capture returned byte into its lane; a flushed byte is dropped
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && (state == FETCH) && vld_p1)
      word_p2[{lane_p1, 3'b000} +: 8] <= ram_byte_i;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory-controller model, scoreboard of expected words,
// table-driven fetch records plus hand-written flush/reset sequences.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_request_o;
  logic [31:0] if_addr_o;
  logic [1:0]  grant_i;
  logic [7:0]  ram_byte_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_request_o (if_request_o),
    .if_addr_o    (if_addr_o),
    .grant_i      (grant_i),
    .ram_byte_i   (ram_byte_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          pre_at;
    int          pre_len;
    int          ready_wait;
    bit          redirect;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  int          n_cmp;
  int          n_fail;
  int          preempt_left;
  bit          g_prev;
  logic [31:0] a_prev;

  // RAM contents: program bytes at 0..3, otherwise low address byte + 0x30
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h00;
      32'h3: return 8'h00;
      default: return a[7:0] + 8'h30;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory controller model, called once per cycle at the falling edge
  task automatic drive_mem(output bit granted);
    ram_byte_i = g_prev ? mem_rd(a_prev) : 8'hEE;
    granted = 1'b0;
    if (preempt_left > 0) begin
      grant_i = GRANT_MEM;
      preempt_left--;
      g_prev = 1'b0;
    end else if (if_request_o) begin
      grant_i = GRANT_IF;
      a_prev = if_addr_o;
      g_prev = 1'b1;
      granted = 1'b1;
    end else begin
      grant_i = GRANT_NONE;
      g_prev = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req",   {31'd0, if_request_o}, 32'd0);
    check("rst_addr",  if_addr_o, 32'd0);
    check("rst_inst",  inst_o, 32'd0);
    check("rst_pc",    inst_pc_o, 32'd0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] pc, input bit with_ready);
    bit g;
    flush_i = 1'b1;
    flush_pc_i = pc;
    inst_ready_i = with_ready;
    drive_mem(g);
    @(negedge clk);
    flush_i = 1'b0;
    inst_ready_i = 1'b0;
    check("flush_valid", {31'd0, inst_valid_o}, 32'd0);
  endtask

  // Entered and left positioned at a falling edge before any stimulus is driven
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] word, input int pre_at,
                          input int pre_len, input int ready_wait, input bit accept,
                          input bit immediate);
    int   issued;
    int   first;
    int   t;
    bit   seen;
    bit   pre_done;
    bit   g;
    exp_t e;
    exp_q.push_back('{pc, word});
    issued = 0;
    first = -1;
    seen = 1'b0;
    pre_done = 1'b0;
    for (t = 0; t < 40; t++) begin
      if (inst_valid_o) begin
        seen = 1'b1;
        break;
      end
      if (if_request_o) begin
        if (first < 0) first = t;
        if (issued == pre_at && !pre_done) begin
          preempt_left = pre_len;
          pre_done = 1'b1;
        end
        check("fetch_addr", if_addr_o, pc + 32'(issued));
      end
      drive_mem(g);
      if (g) issued++;
      @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fetch_timeout: no inst_valid_o for pc %h within 40 cycles", pc);
      void'(exp_q.pop_front());
      return;
    end
    if (immediate) check("restart", 32'(first), 32'd0);
    check("latency", 32'(t - first), 32'(5 + pre_len));
    e = exp_q.pop_front();
    check("inst", inst_o, e.word);
    check("inst_pc", inst_pc_o, e.pc);
    for (int w = 0; w < ready_wait; w++) begin
      drive_mem(g);
      @(negedge clk);
      check("hold_valid", {31'd0, inst_valid_o}, 32'd1);
      check("hold_inst", inst_o, e.word);
      check("hold_pc", inst_pc_o, e.pc);
      check("hold_req", {31'd0, if_request_o}, 32'd0);
    end
    if (accept) begin
      inst_ready_i = 1'b1;
      drive_mem(g);
      @(negedge clk);
      inst_ready_i = 1'b0;
    end
  endtask

  initial begin
    bit g;
    n_cmp = 0;
    n_fail = 0;
    preempt_left = 0;
    g_prev = 1'b0;
    a_prev = 32'd0;
    rst = 1'b1;
    grant_i = GRANT_NONE;
    ram_byte_i = 8'h00;
    flush_i = 1'b0;
    flush_pc_i = 32'd0;
    inst_ready_i = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0513,  2, 2, 0, 1'b1};
    vecs[1] = '{32'h0000_0100, 32'h3332_3130, -1, 0, 3, 1'b1};
    vecs[2] = '{32'hFFFF_FFFE, 32'h0513_2F2E, -1, 0, 0, 1'b1};
    vecs[3] = '{32'h1234_5671, 32'hA4A3_A2A1,  0, 1, 0, 1'b1};
    vecs[4] = '{32'h0000_0080, 32'hB3B2_B1B0,  3, 3, 1, 1'b1};
    vecs[5] = '{32'h0000_0084, 32'hB7B6_B5B4, -1, 0, 0, 1'b0};

    // Reset and first fetch from RESET_PC
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    do_fetch(32'h0, 32'h0000_0513, -1, 0, 0, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].redirect) redirect(vecs[i].pc, 1'b0);
      do_fetch(vecs[i].pc, vecs[i].word, vecs[i].pre_at, vecs[i].pre_len,
               vecs[i].ready_wait, 1'b1, 1'b1);
    end

    // Flush the cycle after byte 0x1 is granted; its returning byte must be dropped
    redirect(32'h0, 1'b0);
    drive_mem(g);
    @(negedge clk);
    drive_mem(g);
    @(negedge clk);
    redirect(32'h100, 1'b0);
    do_fetch(32'h100, 32'h3332_3130, -1, 0, 0, 1'b1, 1'b1);

    // Flush coinciding with a handshake in DONE: flush wins
    redirect(32'h300, 1'b0);
    do_fetch(32'h300, 32'h3332_3130, -1, 0, 0, 1'b0, 1'b1);
    redirect(32'h4C0, 1'b1);
    do_fetch(32'h4C0, 32'hF3F2_F1F0, -1, 0, 0, 1'b1, 1'b1);

    // Back-to-back flushes
    redirect(32'h500, 1'b0);
    redirect(32'h4C0, 1'b0);
    do_fetch(32'h4C0, 32'hF3F2_F1F0, 1, 1, 0, 1'b1, 1'b1);

    // Reset after two bytes captured
    redirect(32'h200, 1'b0);
    repeat (3) begin
      drive_mem(g);
      @(negedge clk);
    end
    rst = 1'b1;
    grant_i = GRANT_NONE;
    g_prev = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    do_fetch(32'h0, 32'h0000_0513, -1, 0, 0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
